// File: rtl/compliance_sig_dump_if.sv
// Bus bundle for the compliance signature dump device.
// Groups the device (register) port, the host (RAM read) port and the testbench-facing
// streaming outputs. Signal names keep the block's port names so waveforms match the docs.
//   slave  : view of compliance_sig_dump itself
//   master : view of the environment (bus fabric, RAM, testbench)
interface compliance_sig_dump_if;
    // Device port: register access from the bus
    logic        dev_req_i;
    logic        dev_we_i;
    logic [31:0] dev_addr_i;
    logic [3:0]  dev_be_i;
    logic [31:0] dev_wdata_i;
    logic        dev_rvalid_o;
    logic [31:0] dev_rdata_o;
    logic        dev_err_o;
    // Host port: signature reads from RAM
    logic        host_req_o;
    logic        host_gnt_i;
    logic [31:0] host_addr_o;
    logic        host_we_o;
    logic [3:0]  host_be_o;
    logic [31:0] host_wdata_o;
    logic        host_rvalid_i;
    logic [31:0] host_rdata_i;
    logic        host_err_i;
    // Streaming outputs towards the testbench
    logic        sig_valid_o;
    logic [31:0] sig_addr_o;
    logic [31:0] sig_data_o;
    logic        char_valid_o;
    logic [7:0]  char_o;
    logic        test_done_o;

    modport slave (
        input  dev_req_i, dev_we_i, dev_addr_i, dev_be_i, dev_wdata_i,
        output dev_rvalid_o, dev_rdata_o, dev_err_o,
        output host_req_o, host_addr_o, host_we_o, host_be_o, host_wdata_o,
        input  host_gnt_i, host_rvalid_i, host_rdata_i, host_err_i,
        output sig_valid_o, sig_addr_o, sig_data_o, char_valid_o, char_o, test_done_o
    );

    modport master (
        output dev_req_i, dev_we_i, dev_addr_i, dev_be_i, dev_wdata_i,
        input  dev_rvalid_o, dev_rdata_o, dev_err_o,
        input  host_req_o, host_addr_o, host_we_o, host_be_o, host_wdata_o,
        output host_gnt_i, host_rvalid_i, host_rdata_i, host_err_i,
        input  sig_valid_o, sig_addr_o, sig_data_o, char_valid_o, char_o, test_done_o
    );
endinterface

// File: rtl/compliance_sig_dump.sv
// Compliance test-utility device.
// The test program sets SIG_BEGIN/SIG_END, prints characters through PUTC and writes CTRL to
// finish. On the CTRL write the block reads the signature region from RAM one word at a time
// over its host port, streams every word out on sig_*, and then raises test_done_o.
// Ports:
//   clk_i   system clock
//   rst_ni  synchronous active-low reset
//   bus     compliance_sig_dump_if.slave: device port (dev_*), RAM host port (host_*),
//           signature stream (sig_*), character stream (char_*), test_done_o
// Registers (word offset from dev_addr_i[9:2]):
//   0x000 SIG_BEGIN RW, 0x004 SIG_END RW, 0x008 CTRL (W start, R {ovf,err,done}), 0x00C PUTC W
module compliance_sig_dump #(
    parameter int unsigned MaxSigWords = 4096
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    compliance_sig_dump_if.slave bus
);
    localparam int unsigned CntW = $clog2(MaxSigWords) + 1;

    localparam logic [7:0] RegBegin = 8'h00;
    localparam logic [7:0] RegEnd   = 8'h01;
    localparam logic [7:0] RegCtrl  = 8'h02;
    localparam logic [7:0] RegPutc  = 8'h03;

    typedef enum logic [2:0] {StIdle, StReq, StWait, StEmit, StDone} state_e;

    state_e          state_q, state_d;
    logic [31:0]     sig_begin_q, sig_begin_d;
    logic [31:0]     sig_end_q, sig_end_d;
    logic [31:0]     ptr_q, ptr_d;
    logic [31:0]     end_q, end_d;
    logic [31:0]     data_q, data_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            err_q, err_d;
    logic            ovf_q, ovf_d;
    logic            rvalid_q;
    logic [31:0]     rdata_q, rdata_d;
    logic            rerr_q, rerr_d;
    logic            char_valid_q, char_valid_d;
    logic [7:0]      char_q, char_d;

    logic [7:0]      reg_idx;
    logic            dev_wr, dev_rd;
    logic [31:0]     start_ptr, start_end, ptr_inc;
    logic            unused_addr;

    assign reg_idx     = bus.dev_addr_i[9:2];
    assign dev_wr      = bus.dev_req_i & bus.dev_we_i;
    assign dev_rd      = bus.dev_req_i & ~bus.dev_we_i;
    assign start_ptr   = sig_begin_q & ~32'h3;
    assign start_end   = sig_end_q & ~32'h3;
    assign ptr_inc     = ptr_q + 32'd4;
    assign cnt_inc     = cnt_q + CntW'(1);
    assign unused_addr = ^{bus.dev_addr_i[31:10], bus.dev_addr_i[1:0]};

    function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

    // Register file, read response and character strobe
    always_comb begin
        sig_begin_d  = sig_begin_q;
        sig_end_d    = sig_end_q;
        rdata_d      = 32'h0;
        rerr_d       = 1'b0;
        char_valid_d = 1'b0;
        char_d       = 8'h0;

        // Bounds are frozen once a dump has started
        if (dev_wr && state_q == StIdle) begin
            if (reg_idx == RegBegin) begin
                sig_begin_d = merge_be(sig_begin_q, bus.dev_wdata_i, bus.dev_be_i);
            end
            if (reg_idx == RegEnd) begin
                sig_end_d = merge_be(sig_end_q, bus.dev_wdata_i, bus.dev_be_i);
            end
        end

        case (reg_idx)
            RegBegin: if (dev_rd) rdata_d = sig_begin_q;
            RegEnd:   if (dev_rd) rdata_d = sig_end_q;
            RegCtrl:  if (dev_rd) rdata_d = {29'd0, ovf_q, err_q, state_q == StDone};
            RegPutc: begin
                if (dev_wr && bus.dev_be_i[0]) begin
                    char_valid_d = 1'b1;
                    char_d       = bus.dev_wdata_i[7:0];
                end
            end
            default:  rerr_d = bus.dev_req_i;
        endcase
    end

    // Dump FSM
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        end_d   = end_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (dev_wr && reg_idx == RegCtrl) begin
                    ptr_d   = start_ptr;
                    end_d   = start_end;
                    cnt_d   = '0;
                    state_d = (start_ptr >= start_end) ? StDone : StReq;
                end
            end
            StReq: begin
                if (bus.host_gnt_i) state_d = StWait;
            end
            StWait: begin
                if (bus.host_rvalid_i) begin
                    data_d  = bus.host_rdata_i;
                    err_d   = err_q | bus.host_err_i;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                ptr_d = ptr_inc;
                cnt_d = cnt_inc;
                if (ptr_inc == end_q) begin
                    state_d = StDone;
                end else if (cnt_inc == CntW'(MaxSigWords)) begin
                    ovf_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StReq;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            sig_begin_q  <= 32'h0;
            sig_end_q    <= 32'h0;
            ptr_q        <= 32'h0;
            end_q        <= 32'h0;
            data_q       <= 32'h0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            ovf_q        <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= 32'h0;
            rerr_q       <= 1'b0;
            char_valid_q <= 1'b0;
            char_q       <= 8'h0;
        end else begin
            state_q      <= state_d;
            sig_begin_q  <= sig_begin_d;
            sig_end_q    <= sig_end_d;
            ptr_q        <= ptr_d;
            end_q        <= end_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            ovf_q        <= ovf_d;
            rvalid_q     <= bus.dev_req_i;
            rdata_q      <= rdata_d;
            rerr_q       <= rerr_d;
            char_valid_q <= char_valid_d;
            char_q       <= char_d;
        end
    end

    assign bus.dev_rvalid_o = rvalid_q;
    assign bus.dev_rdata_o  = rdata_q;
    assign bus.dev_err_o    = rerr_q;

    // Address/data lines are zeroed outside their valid phase to keep idle buses quiet
    assign bus.host_req_o   = (state_q == StReq);
    assign bus.host_addr_o  = (state_q == StReq) ? ptr_q : 32'h0;
    assign bus.host_we_o    = 1'b0;
    assign bus.host_be_o    = 4'hF;
    assign bus.host_wdata_o = 32'h0;

    assign bus.sig_valid_o  = (state_q == StEmit);
    assign bus.sig_addr_o   = (state_q == StEmit) ? ptr_q : 32'h0;
    assign bus.sig_data_o   = (state_q == StEmit) ? data_q : 32'h0;
    assign bus.char_valid_o = char_valid_q;
    assign bus.char_o       = char_q;
    assign bus.test_done_o  = (state_q == StDone);
endmodule

// File: tb/tb_compliance_sig_dump.sv
// Directed testbench for compliance_sig_dump (instantiated with MaxSigWords = 4).
// A small RAM model answers host reads one cycle after the grant cycle; a negedge monitor
// records every signature word. Each task drives one scenario and checks inline.
module tb_compliance_sig_dump;
    logic clk_sys;
    logic rst_sys_n;

    int tests_run    = 0;
    int tests_failed = 0;

    compliance_sig_dump_if bus ();

    compliance_sig_dump #(
        .MaxSigWords(4)
    ) dut (
        .clk_i (clk_sys),
        .rst_ni(rst_sys_n),
        .bus   (bus)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // RAM / host-side model
    logic        gnt_en     = 1'b1;
    logic        ram_en     = 1'b1;
    logic        err_inject = 1'b0;
    logic        inj_rv     = 1'b0;
    logic [31:0] inj_data   = 32'h0;
    logic        pend_q     = 1'b0;
    logic [31:0] pend_addr_q = 32'h0;
    logic        resp_rv_q  = 1'b0;
    logic [31:0] resp_data_q = 32'h0;
    logic        resp_err_q = 1'b0;
    logic [31:0] sig_addr_log[$];
    logic [31:0] sig_data_log[$];
    int          req_cycles = 0;

    assign bus.host_gnt_i    = bus.host_req_o & gnt_en;
    assign bus.host_rvalid_i = resp_rv_q | inj_rv;
    assign bus.host_rdata_i  = inj_rv ? inj_data : resp_data_q;
    assign bus.host_err_i    = resp_rv_q & resp_err_q;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h2000: return 32'h11111111;
            32'h2004: return 32'h22222222;
            32'h2008: return 32'h33333333;
            default:  return a ^ 32'hDEAD0000;
        endcase
    endfunction

    always @(negedge clk_sys) begin
        pend_q      <= bus.host_req_o & bus.host_gnt_i & ram_en;
        pend_addr_q <= bus.host_addr_o;
        resp_rv_q   <= pend_q;
        resp_data_q <= mem_word(pend_addr_q);
        resp_err_q  <= err_inject;
        if (bus.sig_valid_o) begin
            sig_addr_log.push_back(bus.sig_addr_o);
            sig_data_log.push_back(bus.sig_data_o);
        end
        if (bus.host_req_o) req_cycles <= req_cycles + 1;
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic dev_access(input logic we, input logic [9:0] off, input logic [31:0] wdata,
                              input logic [3:0] be, output logic rv, output logic [31:0] rd,
                              output logic er);
        bus.dev_req_i   = 1'b1;
        bus.dev_we_i    = we;
        bus.dev_addr_i  = 32'h20000 | {22'd0, off};
        bus.dev_be_i    = be;
        bus.dev_wdata_i = wdata;
        tick();
        rv = bus.dev_rvalid_o;
        rd = bus.dev_rdata_o;
        er = bus.dev_err_o;
        bus.dev_req_i   = 1'b0;
        bus.dev_we_i    = 1'b0;
        bus.dev_addr_i  = 32'h0;
        bus.dev_be_i    = 4'h0;
        bus.dev_wdata_i = 32'h0;
    endtask

    task automatic do_reset();
        rst_sys_n = 1'b0;
        tick();
        tick();
        rst_sys_n = 1'b1;
    endtask

    task automatic wait_done(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.test_done_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic rv, er;
        logic [31:0] rd;
        rst_sys_n = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({bus.test_done_o, bus.host_req_o, bus.sig_valid_o, bus.dev_rvalid_o,
             bus.char_valid_o} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: done/req/sig/rvalid/char = %b, want 00000",
                     {bus.test_done_o, bus.host_req_o, bus.sig_valid_o, bus.dev_rvalid_o,
                      bus.char_valid_o});
        end
        tests_run++;
        if ({bus.host_be_o, bus.host_addr_o} !== {4'hF, 32'h0}) begin
            tests_failed++;
            $display("FAIL reset_host: be=%h addr=%h, want be=f addr=0",
                     bus.host_be_o, bus.host_addr_o);
        end
        rst_sys_n = 1'b1;
        dev_access(1'b0, 10'h000, 32'h0, 4'h0, rv, rd, er);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_begin: got %h, want 0", rd);
        end
    endtask

    task automatic test_regs();
        logic rv, er;
        logic [31:0] rd;
        dev_access(1'b1, 10'h000, 32'h2000, 4'hF, rv, rd, er);
        tests_run++;
        if ({rv, er, rd} !== {1'b1, 1'b0, 32'h0}) begin
            tests_failed++;
            $display("FAIL write_resp: rv=%b err=%b rdata=%h, want 1 0 0", rv, er, rd);
        end
        tick();
        tests_run++;
        if (bus.dev_rvalid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rvalid_pulse: got %b, want 0", bus.dev_rvalid_o);
        end
        dev_access(1'b0, 10'h000, 32'h0, 4'h0, rv, rd, er);
        tests_run++;
        if ({rv, er, rd} !== {1'b1, 1'b0, 32'h2000}) begin
            tests_failed++;
            $display("FAIL begin_rd: rv=%b err=%b rdata=%h, want 1 0 2000", rv, er, rd);
        end
        dev_access(1'b1, 10'h004, 32'hFFFFFFFF, 4'hF, rv, rd, er);
        dev_access(1'b1, 10'h004, 32'hAABBCCDD, 4'b0101, rv, rd, er);
        dev_access(1'b0, 10'h004, 32'h0, 4'h0, rv, rd, er);
        tests_run++;
        if (rd !== 32'hFFBBFFDD) begin
            tests_failed++;
            $display("FAIL end_be: got %h, want ffbbffdd", rd);
        end
        dev_access(1'b0, 10'h010, 32'h0, 4'h0, rv, rd, er);
        tests_run++;
        if ({rv, er, rd} !== {1'b1, 1'b1, 32'h0}) begin
            tests_failed++;
            $display("FAIL bad_off_rd: rv=%b err=%b rdata=%h, want 1 1 0", rv, er, rd);
        end
        dev_access(1'b1, 10'h3FC, 32'h1234, 4'hF, rv, rd, er);
        tests_run++;
        if (er !== 1'b1) begin
            tests_failed++;
            $display("FAIL bad_off_wr: err=%b, want 1", er);
        end
        dev_access(1'b0, 10'h000, 32'h0, 4'h0, rv, rd, er);
        tests_run++;
        if (rd !== 32'h2000) begin
            tests_failed++;
            $display("FAIL bad_off_keep: begin=%h, want 2000", rd);
        end
    endtask

    task automatic test_dump();
        logic rv, er, ok;
        logic [31:0] rd;
        logic [31:0] exp_data [3];
        int n0;
        exp_data = '{32'h11111111, 32'h22222222, 32'h33333333};
        do_reset();
        dev_access(1'b1, 10'h000, 32'h2000, 4'hF, rv, rd, er);
        dev_access(1'b1, 10'h004, 32'h200C, 4'hF, rv, rd, er);
        n0 = sig_addr_log.size();
        dev_access(1'b1, 10'h008, 32'h1, 4'hF, rv, rd, er);
        wait_done(ok);
        tick();
        tests_run++;
        if (ok !== 1'b1 || sig_addr_log.size() - n0 != 3) begin
            tests_failed++;
            $display("FAIL dump_count: done=%b words=%0d, want 1 3", ok, sig_addr_log.size() - n0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if ({sig_addr_log[n0+i], sig_data_log[n0+i]} !==
                    {32'h2000 + 32'(4 * i), exp_data[i]}) begin
                    tests_failed++;
                    $display("FAIL dump_word%0d: addr=%h data=%h, want %h %h", i,
                             sig_addr_log[n0+i], sig_data_log[n0+i], 32'h2000 + 32'(4 * i),
                             exp_data[i]);
                end
            end
        end
        dev_access(1'b0, 10'h008, 32'h0, 4'h0, rv, rd, er);
        tests_run++;
        if ({rd, bus.test_done_o} !== {32'h1, 1'b1}) begin
            tests_failed++;
            $display("FAIL dump_ctrl: ctrl=%h done=%b, want 1 1", rd, bus.test_done_o);
        end
    endtask

    task automatic test_empty_range();
        logic rv, er;
        logic [31:0] rd;
        logic [31:0] begins [2];
        int n0, r0;
        logic seen;
        begins = '{32'h2000, 32'h3000};
        for (int c = 0; c < 2; c++) begin
            do_reset();
            dev_access(1'b1, 10'h000, begins[c], 4'hF, rv, rd, er);
            dev_access(1'b1, 10'h004, 32'h2000, 4'hF, rv, rd, er);
            n0 = sig_addr_log.size();
            r0 = req_cycles;
            dev_access(1'b1, 10'h008, 32'h1, 4'hF, rv, rd, er);
            seen = bus.test_done_o;
            if (!seen) begin
                tick();
                seen = bus.test_done_o;
            end
            tick();
            tests_run++;
            if ({seen, sig_addr_log.size() == n0, req_cycles == r0} !== 3'b111) begin
                tests_failed++;
                $display("FAIL empty%0d: done=%b words=%0d reqs=%0d, want 1 0 0", c, seen,
                         sig_addr_log.size() - n0, req_cycles - r0);
            end
        end
        // Bounds writes after completion are dropped without an error
        dev_access(1'b1, 10'h000, 32'h1234, 4'hF, rv, rd, er);
        tests_run++;
        if (er !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_wr_err: err=%b, want 0", er);
        end
        dev_access(1'b0, 10'h000, 32'h0, 4'h0, rv, rd, er);
        tests_run++;
        if (rd !== 32'h3000) begin
            tests_failed++;
            $display("FAIL done_wr_drop: begin=%h, want 3000", rd);
        end
    endtask

    task automatic test_stall_and_err();
        logic rv, er, ok;
        logic [31:0] rd;
        int n0;
        do_reset();
        gnt_en = 1'b0;
        dev_access(1'b1, 10'h000, 32'h2000, 4'hF, rv, rd, er);
        dev_access(1'b1, 10'h004, 32'h2004, 4'hF, rv, rd, er);
        n0 = sig_addr_log.size();
        dev_access(1'b1, 10'h008, 32'h1, 4'hF, rv, rd, er);
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({bus.host_req_o, bus.host_addr_o, bus.host_we_o} !== {1'b1, 32'h2000, 1'b0}) begin
                tests_failed++;
                $display("FAIL stall_cyc%0d: req=%b addr=%h we=%b, want 1 2000 0", i,
                         bus.host_req_o, bus.host_addr_o, bus.host_we_o);
            end
            tick();
        end
        err_inject = 1'b1;
        gnt_en     = 1'b1;
        wait_done(ok);
        tick();
        err_inject = 1'b0;
        tests_run++;
        if (ok !== 1'b1 || sig_addr_log.size() - n0 != 1) begin
            tests_failed++;
            $display("FAIL stall_count: done=%b words=%0d, want 1 1", ok, sig_addr_log.size() - n0);
        end else begin
            tests_run++;
            if ({sig_addr_log[n0], sig_data_log[n0]} !== {32'h2000, 32'h11111111}) begin
                tests_failed++;
                $display("FAIL stall_word: addr=%h data=%h, want 2000 11111111",
                         sig_addr_log[n0], sig_data_log[n0]);
            end
        end
        dev_access(1'b0, 10'h008, 32'h0, 4'h0, rv, rd, er);
        tests_run++;
        if (rd !== 32'h3) begin
            tests_failed++;
            $display("FAIL err_flag: ctrl=%h, want 3", rd);
        end
    endtask

    task automatic test_putc();
        logic rv, er;
        logic [31:0] rd;
        dev_access(1'b1, 10'h00C, 32'hFFFFFF48, 4'hF, rv, rd, er);
        tests_run++;
        if ({bus.char_valid_o, bus.char_o} !== {1'b1, 8'h48}) begin
            tests_failed++;
            $display("FAIL putc_h: valid=%b char=%h, want 1 48", bus.char_valid_o, bus.char_o);
        end
        dev_access(1'b1, 10'h00C, 32'h00000069, 4'hF, rv, rd, er);
        tests_run++;
        if ({bus.char_valid_o, bus.char_o} !== {1'b1, 8'h69}) begin
            tests_failed++;
            $display("FAIL putc_i: valid=%b char=%h, want 1 69", bus.char_valid_o, bus.char_o);
        end
        tick();
        tests_run++;
        if (bus.char_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL putc_pulse: valid=%b, want 0", bus.char_valid_o);
        end
        dev_access(1'b1, 10'h00C, 32'h41414141, 4'b1110, rv, rd, er);
        tests_run++;
        if (bus.char_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL putc_be: valid=%b, want 0", bus.char_valid_o);
        end
        dev_access(1'b0, 10'h00C, 32'h0, 4'h0, rv, rd, er);
        tests_run++;
        if ({er, rd} !== {1'b0, 32'h0}) begin
            tests_failed++;
            $display("FAIL putc_rd: err=%b rdata=%h, want 0 0", er, rd);
        end
    endtask

    task automatic test_overflow();
        logic rv, er, ok;
        logic [31:0] rd, a;
        int n0;
        do_reset();
        dev_access(1'b1, 10'h000, 32'h4000, 4'hF, rv, rd, er);
        dev_access(1'b1, 10'h004, 32'h4020, 4'hF, rv, rd, er);
        n0 = sig_addr_log.size();
        dev_access(1'b1, 10'h008, 32'h1, 4'hF, rv, rd, er);
        wait_done(ok);
        tick();
        tests_run++;
        if (ok !== 1'b1 || sig_addr_log.size() - n0 != 4) begin
            tests_failed++;
            $display("FAIL ovf_count: done=%b words=%0d, want 1 4", ok, sig_addr_log.size() - n0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                a = 32'h4000 + 32'(4 * i);
                tests_run++;
                if ({sig_addr_log[n0+i], sig_data_log[n0+i]} !== {a, a ^ 32'hDEAD0000}) begin
                    tests_failed++;
                    $display("FAIL ovf_word%0d: addr=%h data=%h, want %h %h", i,
                             sig_addr_log[n0+i], sig_data_log[n0+i], a, a ^ 32'hDEAD0000);
                end
            end
        end
        dev_access(1'b0, 10'h008, 32'h0, 4'h0, rv, rd, er);
        tests_run++;
        if (rd !== 32'h5) begin
            tests_failed++;
            $display("FAIL ovf_ctrl: ctrl=%h, want 5", rd);
        end
    endtask

    task automatic test_reset_mid_dump();
        logic rv, er, ok, seen;
        logic [31:0] rd;
        int n0;
        do_reset();
        dev_access(1'b1, 10'h000, 32'h2000, 4'hF, rv, rd, er);
        dev_access(1'b1, 10'h004, 32'h200C, 4'hF, rv, rd, er);
        dev_access(1'b1, 10'h008, 32'h1, 4'hF, rv, rd, er);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.sig_valid_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        tests_run++;
        if (seen !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_first_word: seen=%b, want 1", seen);
        end
        // Second read is granted but never answered before the reset
        ram_en = 1'b0;
        tick();
        tick();
        rst_sys_n = 1'b0;
        tick();
        tests_run++;
        if ({bus.host_req_o, bus.sig_valid_o, bus.test_done_o, bus.host_addr_o} !==
            {3'b000, 32'h0}) begin
            tests_failed++;
            $display("FAIL mid_reset_out: req=%b sig=%b done=%b addr=%h, want 0 0 0 0",
                     bus.host_req_o, bus.sig_valid_o, bus.test_done_o, bus.host_addr_o);
        end
        rst_sys_n = 1'b1;
        n0 = sig_addr_log.size();
        inj_rv   = 1'b1;
        inj_data = 32'hBAD0BAD0;
        tick();
        inj_rv = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({sig_addr_log.size() == n0, bus.test_done_o, bus.host_req_o} !== 3'b100) begin
            tests_failed++;
            $display("FAIL late_rvalid: words=%0d done=%b req=%b, want 0 0 0",
                     sig_addr_log.size() - n0, bus.test_done_o, bus.host_req_o);
        end
        ram_en = 1'b1;
        dev_access(1'b1, 10'h000, 32'h2004, 4'hF, rv, rd, er);
        dev_access(1'b1, 10'h004, 32'h200C, 4'hF, rv, rd, er);
        n0 = sig_addr_log.size();
        dev_access(1'b1, 10'h008, 32'h1, 4'hF, rv, rd, er);
        wait_done(ok);
        tick();
        tests_run++;
        if (ok !== 1'b1 || sig_addr_log.size() - n0 != 2) begin
            tests_failed++;
            $display("FAIL redump_count: done=%b words=%0d, want 1 2", ok,
                     sig_addr_log.size() - n0);
        end else begin
            tests_run++;
            if ({sig_addr_log[n0], sig_data_log[n0], sig_addr_log[n0+1], sig_data_log[n0+1]} !==
                {32'h2004, 32'h22222222, 32'h2008, 32'h33333333}) begin
                tests_failed++;
                $display("FAIL redump_words: %h %h %h %h, want 2004 22222222 2008 33333333",
                         sig_addr_log[n0], sig_data_log[n0], sig_addr_log[n0+1],
                         sig_data_log[n0+1]);
            end
        end
        dev_access(1'b0, 10'h008, 32'h0, 4'h0, rv, rd, er);
        tests_run++;
        if (rd !== 32'h1) begin
            tests_failed++;
            $display("FAIL redump_ctrl: ctrl=%h, want 1", rd);
        end
    endtask

    initial begin
        rst_sys_n       = 1'b0;
        bus.dev_req_i   = 1'b0;
        bus.dev_we_i    = 1'b0;
        bus.dev_addr_i  = 32'h0;
        bus.dev_be_i    = 4'h0;
        bus.dev_wdata_i = 32'h0;
        test_reset();
        test_regs();
        test_dump();
        test_empty_range();
        test_stall_and_err();
        test_putc();
        test_overflow();
        test_reset_mid_dump();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
